// File: rtl/byte_striping_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_striping_pkg
// Description : Shared types and constants for the byte striping block.
//               Lane type, assembler state type, lane count, default
//               filler byte, FIFO entry width and a lane-parity helper.
//               FIFO entry width grows by NUM_LANES parity bits when
//               BYTE_STRIPING_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_striping_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;

  localparam logic [LANE_W-1:0] PAD_SYM_DEFAULT = 8'hBC;

`ifdef BYTE_STRIPING_PARITY_EN
  localparam int FIFO_W = WORD_W + NUM_LANES;
`else
  localparam int FIFO_W = WORD_W;
`endif

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } state_e;

  // Bit n is the XOR of lane n, so lane plus parity bit has even weight.
  function automatic logic [NUM_LANES-1:0] lane_parity(input logic [WORD_W-1:0] word);
    logic [NUM_LANES-1:0] par;
    par = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      par[i] = ^word[i*LANE_W +: LANE_W];
    end
    return par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_striping_if.sv
`default_nettype none
// ============================================================================
// Module      : byte_striping_if
// Description : Byte-side and word-side handshake bundle of byte_striping.
//               Byte side : IN_ENB, IN_DATA, IN_VALID, IN_READY, IN_FLUSH
//               Word side : OUT_LANE0..3, OUT_VALID, OUT_READY
//               Optional  : OUT_PARITY (only with BYTE_STRIPING_PARITY_EN)
//               modport slave  - the striping block
//               modport master - the environment driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_striping_if;
  import byte_striping_pkg::*;

  logic  IN_ENB;
  lane_t IN_DATA;
  logic  IN_VALID;
  logic  IN_READY;
  logic  IN_FLUSH;

  lane_t OUT_LANE0;
  lane_t OUT_LANE1;
  lane_t OUT_LANE2;
  lane_t OUT_LANE3;
  logic  OUT_VALID;
  logic  OUT_READY;

`ifdef BYTE_STRIPING_PARITY_EN
  logic [NUM_LANES-1:0] OUT_PARITY;
`endif

  modport slave (
    input  IN_ENB, IN_DATA, IN_VALID, IN_FLUSH, OUT_READY,
`ifdef BYTE_STRIPING_PARITY_EN
    output OUT_PARITY,
`endif
    output IN_READY, OUT_LANE0, OUT_LANE1, OUT_LANE2, OUT_LANE3, OUT_VALID
  );

  modport master (
    output IN_ENB, IN_DATA, IN_VALID, IN_FLUSH, OUT_READY,
`ifdef BYTE_STRIPING_PARITY_EN
    input  OUT_PARITY,
`endif
    input  IN_READY, OUT_LANE0, OUT_LANE1, OUT_LANE2, OUT_LANE3, OUT_VALID
  );

endinterface
`default_nettype wire

// File: rtl/byte_striping_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stripe_fifo
// Description : Synchronous word FIFO between the lane assembler and the
//               downstream parallel-to-serial stage. Pointers carry one
//               extra wrap bit so full and empty are told apart without a
//               counter. Read data is the head entry, valid while !o_empty.
// Ports       : clk, rst_n (async, active low)
//               i_push/i_wdata - write one entry (ignored when full)
//               i_pop          - drop head entry (ignored when empty)
//               o_rdata        - head entry
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module stripe_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wptr;
  logic [c_AW:0]      r_rptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{c_AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{c_AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/byte_striping.sv
`default_nettype none
// ============================================================================
// Module      : byte_striping
// Description : Collects a byte stream into 4-byte words (LANE0 = first byte)
//               and queues them in stripe_fifo for a parallel-to-serial
//               stage. IN_FLUSH closes a partial word, padding the unused
//               lanes with PAD_SYM. Idle lanes drive PAD_SYM.
// Ports       : IN_CLK_2MHz - byte-rate clock
//               IN_RESET    - asynchronous active-low reset
//               bus         - byte_striping_if.slave (byte and word sides)
// Parameters  : DEPTH   - FIFO depth in words, power of two >= 2
//               PAD_SYM - filler byte
// Options     : BYTE_STRIPING_PARITY_EN - adds bus.OUT_PARITY, per-lane even
//               parity stored in the FIFO with each word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int    DEPTH   = 4,
  parameter lane_t PAD_SYM = PAD_SYM_DEFAULT
) (
  input  logic           IN_CLK_2MHz,
  input  logic           IN_RESET,
  byte_striping_if.slave bus
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("byte_striping: DEPTH must be a power of two and at least 2");
  end

  state_e            r_state;
  logic [1:0]        r_ptr;
  lane_t             r_word [NUM_LANES];
  logic              r_flush_pend;
  logic              r_run;

  logic              w_enb;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_flush_req;
  logic              w_push;
  logic              w_pop;
  logic              w_arm_pend;
  logic [WORD_W-1:0] w_word_flat;
  logic [FIFO_W-1:0] w_wdata;
  logic [FIFO_W-1:0] w_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  // r_run holds the block off until the first rising edge after reset
  // release, so an input byte cannot slip in asynchronously.
  assign w_enb       = bus.IN_ENB && r_run;
  assign w_in_ready  = w_enb && !w_fifo_full && !r_flush_pend;
  assign w_accept    = bus.IN_VALID && w_in_ready;
  assign w_last      = w_accept && (r_ptr == 2'd3);
  assign w_flush_req = w_enb && (bus.IN_FLUSH || r_flush_pend);

  // A flush with a same-edge byte in EMPTY still produces a padded word.
  assign w_push = w_enb && !w_fifo_full &&
                  (w_last || (w_flush_req && ((r_state == ST_FILL) || w_accept)));

  // A flush that cannot push yet is remembered until space opens up.
  assign w_arm_pend = w_enb && bus.IN_FLUSH && (r_state == ST_FILL) && !w_push;

  assign w_pop = bus.OUT_READY && !w_fifo_empty;

  // Word as it would be pushed this cycle: held lanes, then the incoming
  // byte at the pointer, then padding for anything not yet filled.
  always_comb begin
    w_word_flat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i < int'(r_ptr)) begin
        w_word_flat[i*LANE_W +: LANE_W] = r_word[i];
      end else if ((i == int'(r_ptr)) && w_accept) begin
        w_word_flat[i*LANE_W +: LANE_W] = bus.IN_DATA;
      end else begin
        w_word_flat[i*LANE_W +: LANE_W] = PAD_SYM;
      end
    end
  end

`ifdef BYTE_STRIPING_PARITY_EN
  assign w_wdata = {lane_parity(w_word_flat), w_word_flat};
`else
  assign w_wdata = w_word_flat;
`endif

  always_ff @(posedge IN_CLK_2MHz or negedge IN_RESET) begin
    if (!IN_RESET) begin
      r_state      <= ST_EMPTY;
      r_ptr        <= 2'd0;
      r_flush_pend <= 1'b0;
      r_run        <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_word[i] <= PAD_SYM;
      end
    end else begin
      r_run <= 1'b1;
      if (w_push) begin
        r_state      <= ST_EMPTY;
        r_ptr        <= 2'd0;
        r_flush_pend <= 1'b0;
      end else if (w_accept) begin
        r_word[r_ptr] <= bus.IN_DATA;
        r_ptr         <= r_ptr + 2'd1;
        r_state       <= ST_FILL;
      end else if (w_arm_pend) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  stripe_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (IN_CLK_2MHz),
    .rst_n   (IN_RESET),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = !w_fifo_empty;
  assign bus.OUT_LANE0 = w_fifo_empty ? PAD_SYM : w_rdata[0*LANE_W +: LANE_W];
  assign bus.OUT_LANE1 = w_fifo_empty ? PAD_SYM : w_rdata[1*LANE_W +: LANE_W];
  assign bus.OUT_LANE2 = w_fifo_empty ? PAD_SYM : w_rdata[2*LANE_W +: LANE_W];
  assign bus.OUT_LANE3 = w_fifo_empty ? PAD_SYM : w_rdata[3*LANE_W +: LANE_W];

`ifdef BYTE_STRIPING_PARITY_EN
  assign bus.OUT_PARITY = w_fifo_empty ? '0 : w_rdata[WORD_W +: NUM_LANES];
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_striping.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_striping
// Description : Self-checking bench for byte_striping. A queue-based model
//               (partial-word byte queue plus word queue) predicts OUT_VALID,
//               the lanes and IN_READY every cycle; scenario tasks add
//               directed checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_striping;

  localparam int         DEPTH = 4;
  localparam logic [7:0] PAD   = 8'hBC;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  byte_striping_if bif();

  byte_striping #(
    .DEPTH   (DEPTH),
    .PAD_SYM (PAD)
  ) dut (
    .IN_CLK_2MHz (clk),
    .IN_RESET    (rst_n),
    .bus         (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  part[$];
  logic [31:0] words[$];
  bit          pend;
  bit          run;

  task automatic model_reset();
    part.delete();
    words.delete();
    pend = 1'b0;
    run  = 1'b0;
  endtask

  function automatic logic [31:0] pad_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = (i < part.size()) ? part[i] : PAD;
    return w;
  endfunction

  function automatic bit exp_ready();
    return run && (bif.IN_ENB === 1'b1) && (words.size() < DEPTH) && !pend;
  endfunction

  task automatic model_edge();
    bit full;
    bit acc;
    full = (words.size() == DEPTH);
    acc  = (bif.IN_VALID === 1'b1) && exp_ready();
    if (words.size() > 0 && bif.OUT_READY === 1'b1) void'(words.pop_front());
    if (run && bif.IN_ENB === 1'b1) begin
      if (acc) part.push_back(bif.IN_DATA);
      if (part.size() == 4 || ((bif.IN_FLUSH === 1'b1 || pend) && part.size() > 0)) begin
        if (!full) begin
          words.push_back(pad_word());
          part.delete();
          pend = 1'b0;
        end else begin
          pend = 1'b1;
        end
      end
    end
    run = 1'b1;
  endtask

  function automatic logic [33:0] expv();
    logic [31:0] w;
    w = (words.size() > 0) ? words[0] : {4{PAD}};
    return {words.size() > 0, w, exp_ready()};
  endfunction

  function automatic logic [33:0] obs();
    return {bif.OUT_VALID, bif.OUT_LANE3, bif.OUT_LANE2, bif.OUT_LANE1, bif.OUT_LANE0, bif.IN_READY};
  endfunction

  function automatic logic [31:0] dut_word();
    return {bif.OUT_LANE3, bif.OUT_LANE2, bif.OUT_LANE1, bif.OUT_LANE0};
  endfunction

  // Inputs are driven just after a falling edge; this advances one rising
  // edge, updates the model with the inputs seen there, and returns at the
  // next falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bif.IN_ENB    = 1'b1;
    bif.IN_VALID  = 1'b0;
    bif.IN_DATA   = 8'h00;
    bif.IN_FLUSH  = 1'b0;
    bif.OUT_READY = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    bif.IN_VALID = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (obs() !== {1'b0, {4{PAD}}, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state got %h exp %h", obs(), {1'b0, {4{PAD}}, 1'b0});
    end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bif.IN_READY !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_ready got %b exp 0", bif.IN_READY);
    end
    step();
    bif.IN_VALID = 1'b0;
    #1;
    n_checks++;
    if (bif.IN_READY !== 1'b1 || bif.OUT_VALID !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_after_edge got ready=%b valid=%b exp ready=1 valid=0", bif.IN_READY, bif.OUT_VALID);
    end
  endtask

  task automatic test_basic();
    drive_idle();
    for (int b = 1; b <= 4; b++) begin
      bif.IN_VALID = 1'b1;
      bif.IN_DATA  = 8'(b);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL basic_cycle got %h exp %h", obs(), expv());
      end
      step();
    end
    bif.IN_VALID = 1'b0;
    #1;
    n_checks++;
    if (bif.OUT_VALID !== 1'b1 || dut_word() !== 32'h04030201) begin
      n_errors++;
      $display("FAIL basic_word got valid=%b word=%h exp valid=1 word=04030201", bif.OUT_VALID, dut_word());
    end
    step();
    #1;
    n_checks++;
    if (obs() !== expv()) begin
      n_errors++;
      $display("FAIL basic_pop got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_flush();
    // {valid, flush, data}
    logic [9:0] tbl [12];
    tbl = '{10'h2AA, 10'h2BB, 10'h100, 10'h211, 10'h222, 10'h233,
            10'h244, 10'h201, 10'h302, 10'h100, 10'h000, 10'h000};
    drive_idle();
    for (int i = 0; i < 12; i++) begin
      bif.IN_VALID = tbl[i][9];
      bif.IN_FLUSH = tbl[i][8];
      bif.IN_DATA  = tbl[i][7:0];
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL flush_cycle %0d got %h exp %h", i, obs(), expv());
      end
      if (i == 3 || i == 7 || i == 9 || i == 10) begin
        logic [32:0] want;
        case (i)
          3:       want = {1'b1, PAD, PAD, 8'hBB, 8'hAA};
          7:       want = {1'b1, 32'h44332211};
          9:       want = {1'b1, PAD, PAD, 8'h02, 8'h01};
          default: want = {1'b0, {4{PAD}}};
        endcase
        n_checks++;
        if ({bif.OUT_VALID, dut_word()} !== want) begin
          n_errors++;
          $display("FAIL flush_word %0d got %h exp %h", i, {bif.OUT_VALID, dut_word()}, want);
        end
      end
      step();
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] sent[$];
    logic [7:0] recv[$];
    logic [7:0] b;
    int acc;
    int cyc;
    int bad;
    acc = 0;
    cyc = 0;
    drive_idle();
    b = 8'($urandom);
    while (acc < 20 && cyc < 200) begin
      bif.IN_VALID  = 1'b1;
      bif.IN_DATA   = b;
      bif.OUT_READY = (cyc >= 30);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL bp_cycle %0d got %h exp %h", cyc, obs(), expv());
      end
      if (cyc == 24) begin
        n_checks++;
        if (bif.IN_READY !== 1'b0 || bif.OUT_VALID !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_full got ready=%b valid=%b exp ready=0 valid=1", bif.IN_READY, bif.OUT_VALID);
        end
      end
      if (bif.OUT_VALID === 1'b1 && bif.OUT_READY === 1'b1)
        for (int k = 0; k < 4; k++) recv.push_back(dut_word() >> (8 * k));
      if (exp_ready()) begin
        sent.push_back(b);
        acc++;
        b = 8'($urandom);
      end
      step();
      cyc++;
    end
    n_checks++;
    if (acc != 20) begin
      n_errors++;
      $display("FAIL bp_timeout got %0d bytes accepted exp 20", acc);
    end
    bif.IN_VALID  = 1'b0;
    bif.OUT_READY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL bp_drain got %h exp %h", obs(), expv());
      end
      if (bif.OUT_VALID === 1'b1)
        for (int k = 0; k < 4; k++) recv.push_back(dut_word() >> (8 * k));
      step();
    end
    bad = (recv.size() != 20 || sent.size() != 20) ? 1 : 0;
    for (int k = 0; k < 20 && bad == 0; k++) if (recv[k] !== sent[k]) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL bp_delivery got %0d bytes exp %0d in order", recv.size(), sent.size());
    end
  endtask

  task automatic test_enable();
    drive_idle();
    bif.OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bif.IN_VALID = 1'b1;
      bif.IN_DATA  = 8'($urandom);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL enb_fill got %h exp %h", obs(), expv());
      end
      step();
    end
    bif.IN_ENB    = 1'b0;
    bif.OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bif.IN_DATA = 8'($urandom);
      bif.IN_FLUSH = (i == 5);
      #1;
      n_checks++;
      if (obs() !== expv() || bif.IN_READY !== 1'b0) begin
        n_errors++;
        $display("FAIL enb_off got %h exp %h", obs(), expv());
      end
      step();
    end
    #1;
    n_checks++;
    if (bif.OUT_VALID !== 1'b0) begin
      n_errors++;
      $display("FAIL enb_drained got valid=%b exp 0", bif.OUT_VALID);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    bif.OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bif.IN_VALID = 1'b1;
      bif.IN_DATA  = 8'($urandom);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL rmid_fill got %h exp %h", obs(), expv());
      end
      step();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== {1'b0, {4{PAD}}, 1'b0}) begin
      n_errors++;
      $display("FAIL rmid_async got %h exp %h", obs(), {1'b0, {4{PAD}}, 1'b0});
    end
    step();
    rst_n = 1'b1;
    step();
    bif.OUT_READY = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bif.IN_DATA = 8'h50 + 8'(b);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL rmid_cycle got %h exp %h", obs(), expv());
      end
      step();
    end
    bif.IN_VALID = 1'b0;
    #1;
    n_checks++;
    if (bif.OUT_VALID !== 1'b1 || dut_word() !== 32'h53525150) begin
      n_errors++;
      $display("FAIL rmid_word got valid=%b word=%h exp valid=1 word=53525150", bif.OUT_VALID, dut_word());
    end
    step();
  endtask

`ifdef BYTE_STRIPING_PARITY_EN
  task automatic test_parity();
    logic [7:0] seq [4];
    seq = '{8'h01, 8'h03, 8'h07, 8'h00};
    drive_idle();
    #1;
    n_checks++;
    if (bif.OUT_PARITY !== 4'b0000) begin
      n_errors++;
      $display("FAIL parity_idle got %b exp 0000", bif.OUT_PARITY);
    end
    for (int i = 0; i < 4; i++) begin
      bif.IN_VALID = 1'b1;
      bif.IN_DATA  = seq[i];
      step();
    end
    bif.IN_VALID = 1'b0;
    #1;
    n_checks++;
    if (bif.OUT_PARITY !== 4'b0101 || dut_word() !== 32'h00070301) begin
      n_errors++;
      $display("FAIL parity_word got par=%b word=%h exp par=0101 word=00070301", bif.OUT_PARITY, dut_word());
    end
    step();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bif.IN_ENB    = ($urandom_range(0, 7) != 0);
      bif.IN_VALID  = ($urandom_range(0, 3) != 0);
      bif.IN_DATA   = 8'($urandom);
      bif.IN_FLUSH  = ($urandom_range(0, 9) == 0);
      bif.OUT_READY = ($urandom_range(0, 9) < 6);
      #1;
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++;
        $display("FAIL random_cycle %0d got %h exp %h", c, obs(), expv());
      end
      step();
    end
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_enable();
    test_reset_mid();
`ifdef BYTE_STRIPING_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/byte_striping.md
BYTE_STRIPING -- requirements
Module: byte_striping

Interface
REQ-001 Parameter DEPTH, default 4: word FIFO depth; power of two, minimum 2.
REQ-002 Parameter PAD_SYM, default 8'hBC: filler byte for unused lanes and the idle output.
REQ-003 IN_CLK_2MHz  in  1  byte-rate clock; all state changes on the rising edge.
REQ-004 IN_RESET  in  1  asynchronous, active-low reset.
REQ-005 IN_ENB  in  1  block enable.
REQ-006 IN_DATA  in  8  input byte.
REQ-007 IN_VALID  in  1  IN_DATA qualifier.
REQ-008 IN_READY  out  1  block can accept a byte.
REQ-009 IN_FLUSH  in  1  one-cycle pulse: close the current partial word.
REQ-010 OUT_LANE0..OUT_LANE3  out  8 each  striped word; LANE0 holds the first byte.
REQ-011 OUT_VALID  out  1  a word is presented on the lanes.
REQ-012 OUT_READY  in  1  the downstream parallel-to-serial stage takes the presented word.

Function
REQ-013 A byte SHALL be accepted only on an edge where IN_VALID and IN_READY are both 1.
REQ-014 IN_READY SHALL equal IN_ENB AND (FIFO not full).
REQ-015 The assembler SHALL be a two-state FSM with states:
- EMPTY: lane pointer = 0.
- FILL: lane pointer = 1..3.
REQ-016 Byte placement and FSM transitions:
- Each accepted byte goes to the lane named by the pointer.
- The pointer increments and wraps 3->0.
- EMPTY->FILL on the first byte; FILL->EMPTY on the fourth byte or on a flush.
REQ-017 The edge that accepts the fourth byte SHALL push the 4-byte word into the FIFO.
REQ-018 OUT_VALID SHALL assert on the cycle after that push when the FIFO was empty, giving 1-cycle latency from the 4th byte.
REQ-019 IN_FLUSH in state FILL:
- Fill the remaining lanes with PAD_SYM.
- Push the word and return the FSM to EMPTY.
- A byte accepted on the same edge SHALL be placed before padding.
REQ-020 IN_FLUSH in state EMPTY, with no byte accepted on that edge, SHALL have no effect.
REQ-021 If a flush would push while the FIFO is full, the push SHALL wait; the flush stays pending and IN_READY stays low until the push completes.
REQ-022 A word SHALL pop on each edge where OUT_VALID and OUT_READY are both 1.
REQ-023 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-024 FIFO read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH:
- full = MSBs differ and the remaining bits are equal;
- empty = pointers equal.
REQ-025 While OUT_VALID=0, all OUT_LANEx SHALL drive PAD_SYM.
REQ-026 While OUT_VALID=1, the presented word SHALL stay stable until it is popped.
REQ-027 IN_ENB=0 SHALL freeze the assembler and block pushes; FIFO pops SHALL continue.

Reset
REQ-028 While IN_RESET=0, asynchronously:
- FSM = EMPTY, pointer = 0, FIFO empty;
- OUT_VALID = 0, IN_READY = 0, OUT_LANEx = PAD_SYM.
REQ-029 Reset asserted mid-word or with the FIFO non-empty SHALL discard all data and emit no partial word.
REQ-030 Reset deassertion SHALL take effect only at the next rising edge of IN_CLK_2MHz.

Configuration
REQ-031 With BYTE_STRIPING_PARITY_EN defined:
- Add output OUT_PARITY, 4 bits: even parity of each lane.
- Parity is stored in the FIFO alongside the word.
- Reset value 0; value 0 while idle (PAD_SYM lanes).
REQ-032 Without BYTE_STRIPING_PARITY_EN, the port and its storage SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package byte_striping_pkg SHALL hold:
- the FSM state typedef (ST_EMPTY, ST_FILL);
- the lane type (8-bit);
- the constants NUM_LANES=4 and the PAD_SYM default.
REQ-034 The FIFO SHALL be a sub-module named stripe_fifo, parameterised by DEPTH and width (32 or 36 bits).

Verification
REQ-035 Reset, then bytes 01,02,03,04 on consecutive cycles with OUT_READY=1 -> the cycle after 04: OUT_VALID=1, LANE0..3 = 01,02,03,04.
REQ-036 OUT_READY=0; stream 20 bytes -> 4 words stored, IN_READY=0 after the 16th byte, the remaining 4 bytes held; OUT_READY=1 -> words emerge in order, all 20 bytes delivered.
REQ-037 Bytes AA,BB then IN_FLUSH -> word AA,BB,BC,BC; next byte 11 lands in LANE0.
REQ-038 IN_RESET low after 2 bytes and with 2 words queued -> OUT_VALID=0 immediately; next 4 bytes 0x5x form a clean word.
REQ-039 IN_ENB=0 with IN_VALID=1 for 10 cycles -> nothing accepted, queued words still drain.
REQ-040 With BYTE_STRIPING_PARITY_EN: word 01,03,07,00 -> OUT_PARITY=4'b0101 (bit n = parity of LANEn).
